// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// State enum, opcodes, funct3 values and datapath select codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] r;
        r = IMM_I;
        case (op)
            OP_STORE:  r = IMM_S;
            OP_BRANCH: r = IMM_B;
            OP_JAL:    r = IMM_J;
            default:   r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle FSM and its datapath.
// master = control unit, slave = datapath / memory side.
interface multicycle_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 ir_write;
    logic                 reg_write;
    logic                 mem_req;
    logic                 mem_we;
    logic                 adr_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [2:0]           alu_ctrl;
    logic [1:0]           result_src;
    logic [1:0]           imm_src;
    logic                 trap;
    logic [3:0]           state_dbg;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_req, mem_we,
        output adr_src, alu_src_a, alu_src_b, alu_ctrl,
        output result_src, imm_src, trap, state_dbg, retired
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_req, mem_we,
        input  adr_src, alu_src_a, alu_src_b, alu_ctrl,
        input  result_src, imm_src, trap, state_dbg, retired
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode for OP / OP-IMM instructions.
// Also reports whether funct3 is one the core implements.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    // funct7b5 only selects sub for register-register ops
    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (funct3)
            F3_ADD:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            F3_SLT:  alu_ctrl = ALU_SLT;
            F3_OR:   alu_ctrl = ALU_OR;
            F3_AND:  alu_ctrl = ALU_AND;
            default: legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute,
// memory and writeback; stalls on mem_ready, counts retirements.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
);

    state_e               state_q, state_d;
    logic                 trap_q, trap_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic [2:0] dec_alu_ctrl;
    logic       dec_legal;
    logic       is_rtype;
    logic       retire;

    assign is_rtype = (bus.op == OP_REG);

    alu_decoder u_alu_dec (
        .funct3   (bus.funct3),
        .funct7b5 (bus.funct7b5),
        .is_rtype (is_rtype),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    // Next-state selection, including illegal-instruction detection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:
                if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE:
                case (bus.op)
                    OP_LOAD, OP_STORE:
                        state_d = (bus.funct3 == F3_W) ? S_MEMADR : S_TRAP;
                    OP_REG:
                        state_d = dec_legal ? S_EXECR : S_TRAP;
                    OP_IMM:
                        state_d = dec_legal ? S_EXECI : S_TRAP;
                    OP_JAL:
                        state_d = S_JAL;
                    OP_BRANCH:
                        state_d = (bus.funct3 == F3_BEQ ||
                                   bus.funct3 == F3_BNE) ? S_BRANCH : S_TRAP;
                    default:
                        state_d = S_TRAP;
                endcase
            S_MEMADR:
                state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:
                if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE:
                if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Retirement count and sticky trap flag
    always_comb begin
        retire = (state_d == S_FETCH) &&
                 (state_q == S_MEMWB  || state_q == S_MEMWRITE ||
                  state_q == S_ALUWB  || state_q == S_BRANCH);
        retired_d = retire ? retired_q + CNT_WIDTH'(1) : retired_q;
        trap_d    = trap_q | (state_d == S_TRAP);
    end

    // State, trap and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            trap_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    // Datapath controls decoded from state; everything idle in reset
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_REG;
        bus.alu_ctrl   = ALU_ADD;
        bus.result_src = RES_ALUOUT;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    bus.mem_req    = 1'b1;
                    bus.alu_src_b  = SRCB_FOUR;
                    bus.result_src = RES_ALU;
                    bus.ir_write   = bus.mem_ready;
                    bus.pc_write   = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_a = SRCA_OLDPC;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEMADR: begin
                    bus.alu_src_a = SRCA_REG;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: begin
                    bus.mem_req = 1'b1;
                    bus.adr_src = 1'b1;
                end
                S_MEMWB: begin
                    bus.result_src = RES_MEM;
                    bus.reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = 1'b1;
                    bus.adr_src = 1'b1;
                end
                S_EXECR: begin
                    bus.alu_src_a = SRCA_REG;
                    bus.alu_src_b = SRCB_REG;
                    bus.alu_ctrl  = dec_alu_ctrl;
                end
                S_EXECI: begin
                    bus.alu_src_a = SRCA_REG;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_ctrl  = dec_alu_ctrl;
                end
                S_ALUWB: begin
                    bus.reg_write = 1'b1;
                end
                S_JAL: begin
                    bus.alu_src_a = SRCA_OLDPC;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.pc_write  = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a = SRCA_REG;
                    bus.alu_src_b = SRCB_REG;
                    bus.alu_ctrl  = ALU_SUB;
                    bus.pc_write  = bus.zero ^ bus.funct3[0];
                end
                default: begin
                    bus.pc_write = 1'b0;
                end
            endcase
        end
    end

    assign bus.imm_src   = imm_src_of(bus.op);
    assign bus.trap      = trap_q;
    assign bus.state_dbg = state_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl.
// Table of per-cycle expectations plus short corner-case sequences.
module tb_multicycle_ctrl;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [1:0]  imm;
        logic [31:0] ret;
    } vec_t;

    // {pc_w, ir_w, reg_w, mem_req, mem_we, adr_src,
    //  src_a[2], src_b[2], alu[3], result[2], trap}
    localparam logic [15:0] C_FR  = 16'b1_1_0_1_0_0_00_10_000_10_0;
    localparam logic [15:0] C_FW  = 16'b0_0_0_1_0_0_00_10_000_10_0;
    localparam logic [15:0] C_DEC = 16'b0_0_0_0_0_0_01_01_000_00_0;
    localparam logic [15:0] C_EXI = 16'b0_0_0_0_0_0_10_01_000_00_0;
    localparam logic [15:0] C_MAD = 16'b0_0_0_0_0_0_10_01_000_00_0;
    localparam logic [15:0] C_AWB = 16'b0_0_1_0_0_0_00_00_000_00_0;
    localparam logic [15:0] C_MRD = 16'b0_0_0_1_0_1_00_00_000_00_0;
    localparam logic [15:0] C_MWB = 16'b0_0_1_0_0_0_00_00_000_01_0;
    localparam logic [15:0] C_MWR = 16'b0_0_0_1_1_1_00_00_000_00_0;
    localparam logic [15:0] C_SUB = 16'b0_0_0_0_0_0_10_00_001_00_0;
    localparam logic [15:0] C_AND = 16'b0_0_0_0_0_0_10_00_010_00_0;
    localparam logic [15:0] C_BT  = 16'b1_0_0_0_0_0_10_00_001_00_0;
    localparam logic [15:0] C_BN  = 16'b0_0_0_0_0_0_10_00_001_00_0;
    localparam logic [15:0] C_JAL = 16'b1_0_0_0_0_0_01_10_000_00_0;
    localparam logic [15:0] C_TRP = 16'b0_0_0_0_0_0_00_00_000_00_1;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_BNE  = 32'h00001063;
    localparam logic [31:0] I_SUB  = 32'h40208033;
    localparam logic [31:0] I_AND  = 32'h0020F033;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t tv[$];

    multicycle_ctrl_if #(.CNT_WIDTH(32)) bus ();

    multicycle_ctrl #(.CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wire [15:0] ctl_act = {bus.pc_write, bus.ir_write, bus.reg_write,
                           bus.mem_req, bus.mem_we, bus.adr_src,
                           bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
                           bus.result_src, bus.trap};

    function automatic vec_t mk(input logic r, input logic [31:0] ins,
                                input logic z, input logic rd,
                                input logic [3:0] s, input logic [15:0] c,
                                input logic [1:0] im, input logic [31:0] rt);
        vec_t v;
        v.rst = r; v.instr = ins; v.zero = z; v.rdy = rd;
        v.st = s; v.ctl = c; v.imm = im; v.ret = rt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic z,
                         input logic rd);
        logic [31:0] w;
        w = ins;
        bus.op       = w[6:0];
        bus.funct3   = w[14:12];
        bus.funct7b5 = w[30];
        bus.zero     = z;
        bus.mem_ready = rd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Leaves the bench at the negedge of the cycle where target is seen
    task automatic wait_state(input string name, input logic [3:0] target,
                              input int budget);
        bit hit;
        hit = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            if (bus.state_dbg == target) hit = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk(name, {28'd0, bus.state_dbg}, {28'd0, target});
    endtask

    task automatic expect_trap(input string name, input logic [31:0] ins);
        do_reset();
        drive(ins, 1'b0, 1'b1);
        wait_state({name, "_state"}, 4'd15, 6);
        chk({name, "_trap"}, {31'd0, bus.trap}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic expect_alu(input string name, input logic [31:0] ins,
                              input logic [3:0] st, input logic [2:0] alu);
        do_reset();
        drive(ins, 1'b0, 1'b1);
        wait_state({name, "_state"}, st, 6);
        chk({name, "_alu"}, {29'd0, bus.alu_ctrl}, {29'd0, alu});
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b1);

        // addi
        tv.push_back(mk(0, I_ADDI, 0, 1, 0,  C_FR,  0, 0));
        tv.push_back(mk(0, I_ADDI, 0, 1, 1,  C_DEC, 0, 0));
        tv.push_back(mk(0, I_ADDI, 0, 1, 7,  C_EXI, 0, 0));
        tv.push_back(mk(0, I_ADDI, 0, 1, 8,  C_AWB, 0, 0));
        // lw with three stall cycles
        tv.push_back(mk(0, I_LW,   0, 1, 0,  C_FR,  0, 1));
        tv.push_back(mk(0, I_LW,   0, 1, 1,  C_DEC, 0, 1));
        tv.push_back(mk(0, I_LW,   0, 1, 2,  C_MAD, 0, 1));
        tv.push_back(mk(0, I_LW,   0, 0, 3,  C_MRD, 0, 1));
        tv.push_back(mk(0, I_LW,   0, 0, 3,  C_MRD, 0, 1));
        tv.push_back(mk(0, I_LW,   0, 0, 3,  C_MRD, 0, 1));
        tv.push_back(mk(0, I_LW,   0, 1, 3,  C_MRD, 0, 1));
        tv.push_back(mk(0, I_LW,   0, 1, 4,  C_MWB, 0, 1));
        // sw with fetch stall and write stall
        tv.push_back(mk(0, I_SW,   0, 0, 0,  C_FW,  1, 2));
        tv.push_back(mk(0, I_SW,   0, 1, 0,  C_FR,  1, 2));
        tv.push_back(mk(0, I_SW,   0, 1, 1,  C_DEC, 1, 2));
        tv.push_back(mk(0, I_SW,   0, 1, 2,  C_MAD, 1, 2));
        tv.push_back(mk(0, I_SW,   0, 0, 5,  C_MWR, 1, 2));
        tv.push_back(mk(0, I_SW,   0, 1, 5,  C_MWR, 1, 2));
        // beq taken, beq not taken, bne taken
        tv.push_back(mk(0, I_BEQ,  1, 1, 0,  C_FR,  2, 3));
        tv.push_back(mk(0, I_BEQ,  1, 1, 1,  C_DEC, 2, 3));
        tv.push_back(mk(0, I_BEQ,  1, 1, 10, C_BT,  2, 3));
        tv.push_back(mk(0, I_BEQ,  0, 1, 0,  C_FR,  2, 4));
        tv.push_back(mk(0, I_BEQ,  0, 1, 1,  C_DEC, 2, 4));
        tv.push_back(mk(0, I_BEQ,  0, 1, 10, C_BN,  2, 4));
        tv.push_back(mk(0, I_BNE,  0, 1, 0,  C_FR,  2, 5));
        tv.push_back(mk(0, I_BNE,  0, 1, 1,  C_DEC, 2, 5));
        tv.push_back(mk(0, I_BNE,  0, 1, 10, C_BT,  2, 5));
        // sub, and
        tv.push_back(mk(0, I_SUB,  0, 1, 0,  C_FR,  0, 6));
        tv.push_back(mk(0, I_SUB,  0, 1, 1,  C_DEC, 0, 6));
        tv.push_back(mk(0, I_SUB,  0, 1, 6,  C_SUB, 0, 6));
        tv.push_back(mk(0, I_SUB,  0, 1, 8,  C_AWB, 0, 6));
        tv.push_back(mk(0, I_AND,  0, 1, 0,  C_FR,  0, 7));
        tv.push_back(mk(0, I_AND,  0, 1, 1,  C_DEC, 0, 7));
        tv.push_back(mk(0, I_AND,  0, 1, 6,  C_AND, 0, 7));
        tv.push_back(mk(0, I_AND,  0, 1, 8,  C_AWB, 0, 7));
        // jal
        tv.push_back(mk(0, I_JAL,  0, 1, 0,  C_FR,  3, 8));
        tv.push_back(mk(0, I_JAL,  0, 1, 1,  C_DEC, 3, 8));
        tv.push_back(mk(0, I_JAL,  0, 1, 9,  C_JAL, 3, 8));
        tv.push_back(mk(0, I_JAL,  0, 1, 8,  C_AWB, 3, 8));
        // illegal opcode, sticky trap, then reset
        tv.push_back(mk(0, I_BAD,  0, 1, 0,  C_FR,  0, 9));
        tv.push_back(mk(0, I_BAD,  0, 1, 1,  C_DEC, 0, 9));
        tv.push_back(mk(0, I_BAD,  1, 1, 15, C_TRP, 0, 9));
        tv.push_back(mk(0, I_BAD,  1, 1, 15, C_TRP, 0, 9));
        tv.push_back(mk(1, I_BAD,  1, 1, 15, C_TRP, 0, 9));
        tv.push_back(mk(0, I_ADDI, 0, 1, 0,  C_FR,  0, 0));

        repeat (2) @(posedge clk);
        #1;

        foreach (tv[i]) begin
            rst = tv[i].rst;
            drive(tv[i].instr, tv[i].zero, tv[i].rdy);
            @(negedge clk);
            chk($sformatf("row%0d_state", i),
                {28'd0, bus.state_dbg}, {28'd0, tv[i].st});
            chk($sformatf("row%0d_ctl", i),
                {16'd0, ctl_act}, {16'd0, tv[i].ctl});
            chk($sformatf("row%0d_imm", i),
                {30'd0, bus.imm_src}, {30'd0, tv[i].imm});
            chk($sformatf("row%0d_retired", i), bus.retired, tv[i].ret);
            @(posedge clk); #1;
        end

        // funct3 legality corner cases
        expect_trap("slli", 32'h00101093);
        expect_trap("blt",  32'h00004063);
        expect_trap("lb",   32'h00008103);
        expect_trap("sh",   32'h00209023);
        expect_alu("or_r",   32'h0020E033, 4'd6, 3'b011);
        expect_alu("slti",   32'h0020A093, 4'd7, 3'b101);
        expect_alu("addi_f7", 32'h40008093, 4'd7, 3'b000);

        // reset during writeback must not count the instruction
        do_reset();
        drive(I_ADDI, 1'b0, 1'b1);
        wait_state("mid_rst_awb", 4'd8, 6);
        chk("mid_rst_regw", {31'd0, bus.reg_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_regw_off", {31'd0, bus.reg_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", {28'd0, bus.state_dbg}, 32'd0);
        chk("mid_rst_retired", bus.retired, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle revision of the RV32I core.
- Sequences one shared ALU, the instruction/data memory port and the register file over several clocks per instruction: fetch, decode, execute, memory, writeback.
- Receives decoded instruction fields and the ALU zero flag; drives every datapath enable and mux select.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- op  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU result == 0
- mem_ready  input  1  memory completes the current request this cycle
- pc_write  output  1  PC register load enable
- ir_write  output  1  instruction register and oldPC load enable
- reg_write  output  1  register file write enable
- mem_req  output  1  memory access request
- mem_we  output  1  memory write (valid with mem_req)
- adr_src  output  1  memory address: 0 = PC, 1 = result bus
- alu_src_a  output  2  00 = PC, 01 = oldPC, 10 = register A
- alu_src_b  output  2  00 = register B, 01 = ImmExt, 10 = constant 4
- alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- result_src  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result
- imm_src  output  2  00 I, 01 S, 10 B, 11 J
- trap  output  1  illegal instruction seen; sticky
- state_dbg  output  4  current state encoding
- retired  output  CNT_WIDTH  count of completed instructions

Behaviour:
- Clocking and reset: Single clock. rst is synchronous and active-high.
- Reset values: state = FETCH, retired = 0, trap = 0. All enables are 0 while rst is high. Reset mid-instruction abandons the instruction and does not increment retired.
- Output style: outputs are Moore, decoded from state. Exceptions are pc_write in BRANCH, and the FETCH/MEMREAD/MEMWRITE enables, which are gated by mem_ready.
- imm_src: combinational from op, valid in every state. 0010011/0000011 → 00, 0100011 → 01, 1100011 → 10, 1101111 → 11, otherwise 00.
- Defaults: any select not listed for a state is 00/0.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BRANCH=10, TRAP=15.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=add, result_src=10.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise hold FETCH with ir_write=pc_write=0.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, add (branch target precomputed into ALUOut).
  - Next state by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1101111 → JAL; 1100011 → BRANCH.
  - Any other op → TRAP.
  - OP/OP-IMM with funct3 not in {000, 010, 110, 111} → TRAP.
  - Branch with funct3 not in {000, 001} → TRAP.
  - Load with funct3≠010 or store with funct3≠010 → TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, add. op=0000011 → MEMREAD; otherwise → MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Wait on mem_ready, then → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Wait on mem_ready, then → FETCH.
- EXECR: alu_src_a=10, alu_src_b=00. ALU decode:
  - funct3 000 → sub if funct7b5 else add.
  - 010 → slt; 110 → or; 111 → and.
  - Then → ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01. Same decode but funct3 000 → always add. Then → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 → ALUWB (rd = oldPC+4).
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write = zero XOR funct3[0] → FETCH.
- TRAP: trap=1, all enables 0. Stays in TRAP until rst.
- Retired counter: increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. Wraps at 2^CNT_WIDTH−1 → 0.
- Stalls: mem_ready held low stalls indefinitely with mem_req held high and address select stable. mem_ready is ignored in all other states.

Decomposition:
- Package multicycle_pkg holds:
  - state enum (4-bit, encodings above);
  - opcode constants;
  - alu_ctrl, alu_src, result_src and imm_src localparams.
- One sub-module, alu_decoder: combinational, maps (funct3, funct7b5, is_rtype) → alu_ctrl plus a legal flag used by DECODE.

Test Plan:
- rst high 2 cycles, then addi x1,x0,5 (0x00500093) with mem_ready always 1:
  - states 0,1,7,8,0;
  - reg_write only in cycle 4;
  - retired 0→1.
- lw (0x0000A103) with mem_ready low for 3 cycles in MEMREAD:
  - mem_req=1, adr_src=1 held for 4 cycles;
  - then MEMWB with result_src=01, reg_write=1.
- beq (funct3 000), two cases:
  - zero=1 → pc_write=1 in BRANCH;
  - zero=0 → pc_write=0;
  - bne with zero=0 → pc_write=1;
  - retired +1 each case.
- sub (0x40208033) → EXECR alu_ctrl=001. and (funct3 111) → alu_ctrl=010.
- jal (0x008000EF) → states 0,1,9,8,0; pc_write in JAL; reg_write in ALUWB.
- op=0x7F → DECODE→TRAP, trap=1, no further enables. Assert rst for 1 cycle → FETCH, trap=0, retired=0.
